apb_master_arbiter: RTL
=======================

# apb_master_arbiter

Synthesizable APB master that shares one APB bus between NREQ requesters. Each requester posts a single read or write command. The block grants commands round-robin and runs the APB SETUP/ACCESS sequence on the bus. It then returns read data and a completion pulse to the granted requester. It sits between on-chip agents and the APB slaves that the bench-side driver currently exercises directly.

## Interface
- NREQ, 2: number of requesters (2..8)
- AWIDTH, 4: APB address width
- DWIDTH, 8: APB data width

- pclk  in  1  clock, all logic on rising edge
- preset  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  command pending, one bit per requester
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AWIDTH  packed addresses, requester i at [i*AWIDTH +: AWIDTH]
- req_wdata  in  NREQ*DWIDTH  packed write data, same packing
- req_ready  out  NREQ  one-hot accept, combinational
- rsp_valid  out  NREQ  one-hot completion pulse, registered
- rsp_rdata  out  DWIDTH  read data of the completed read
- psel, penable, pwrite  out  1  APB control
- paddr  out  AWIDTH  APB address
- pwdata  out  DWIDTH  APB write data
- prdata  in  DWIDTH  APB read data
- pready  in  1  APB ready; tie to 1 for zero-wait slaves

## Operation
- Reset state:
  - FSM is IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid and rsp_rdata are all 0.
  - req_ready is 0.
  - Round-robin pointer `last` = NREQ-1, so requester 0 has first priority.
- FSM states:
  - IDLE: bus quiet.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- Grant window: the cycle is IDLE, or it is ACCESS with pready=1.
  - Grant = first requester with req_valid=1, searching last+1, last+2, … modulo NREQ.
  - req_ready[grant]=1 for that cycle only; all other req_ready bits stay 0.
- At the accepting edge:
  - req_write, req_addr and req_wdata of the granted requester are latched into pwrite, paddr and pwdata.
  - `last` := grant.
  - FSM -> SETUP.
- SETUP -> ACCESS unconditionally after one cycle. penable rises; paddr, pwrite and pwdata stay held.
- ACCESS with pready=0: stay in ACCESS; all APB outputs held. Wait cycles are unbounded.
- ACCESS with pready=1 (transfer completes at this edge):
  - rsp_valid[owner] = 1 for exactly one cycle after the edge.
  - For a read, rsp_rdata := prdata. For a write, rsp_rdata holds its previous value.
  - Next state:
    - If a new grant exists this cycle -> SETUP, with penable=0 and psel kept at 1 (back-to-back, no idle cycle).
    - Otherwise -> IDLE, with psel=0 and penable=0.
  - When a new transfer starts, paddr, pwrite and pwdata take the new values. When the bus returns to IDLE they hold their last values.
- Requester rules:
  - Hold req_* stable while req_valid=1 and req_ready=0.
  - Deassert or present the next command after the accept edge.
  - The block never accepts a second command from any requester before the current transfer reaches ACCESS with pready=1.
- Owner: the index of the current transfer is held in a register. rsp_valid is driven from that register, not from the live grant.
- Simultaneous requests: exactly one is granted per window. A requester that was just served has the lowest priority in the next window.
- Asynchronous reset mid-transfer:
  - All outputs return to reset values immediately and FSM goes to IDLE.
  - The in-flight transfer is dropped with no rsp_valid.
  - Requesters must re-post after reset.

## Timing
- Let E = the accept edge.
  - psel=1 and paddr valid after E.
  - penable=1 after E+1.
  - With pready=1, the transfer completes at E+2 and rsp_valid is high for the cycle after E+2.
- Throughput, zero-wait back-to-back: one transfer per 2 cycles.
- Isolated transfer: psel is high for exactly 2 cycles, then low.
- Each pready=0 cycle in ACCESS adds one cycle to the latency.
- rsp_rdata is valid in the same cycle as rsp_valid and stable until the next read completes.

## Structure
- Package apb_pkg holds:
  - typedef enum logic [1:0] apb_state_t {IDLE, SETUP, ACCESS}.
  - Default AWIDTH/DWIDTH constants.
- Sub-module apb_rr_arbiter: purely combinational.
  - Inputs: req_valid and `last`.
  - Outputs: one-hot grant, grant index and any_grant.
  - Owns no state; the pointer register stays in the top level.
- Top level holds: FSM, command/owner registers, APB output registers, response registers.

## Test plan
- Reset, then req_valid[0]=1, write addr=4'h3 data=8'hA5, pready=1 -> req_ready[0] one cycle; psel 2 cycles, penable in the 2nd; paddr=3, pwdata=A5, pwrite=1; rsp_valid[0] one cycle at E+3.
- Read addr=4'h7, slave drives prdata=8'h3C, pready held 0 for 3 ACCESS cycles -> APB outputs stable throughout; rsp_rdata=3C with rsp_valid[0] exactly once; total latency 6 cycles.
- NREQ=2, both requesters valid continuously with distinct commands -> grants alternate 0,1,0,1; psel never drops between transfers; penable toggles 0,1 every cycle.
- Requester 1 alone, then requesters 0 and 1 together after it is served -> requester 0 granted next (rotation from last=1).
- preset asserted while in ACCESS with pready=0 -> psel, penable and rsp_valid go 0 without a clock edge; no rsp_valid after release; next grant goes to requester 0.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type, default widths and index-width helper for the APB master arbiter
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
    localparam int APB_AWIDTH = 4;
    localparam int APB_DWIDTH = 8;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: combinational round-robin pick starting after the last served requester
module apb_rr_arbiter import apb_pkg::*; #(
    parameter int NREQ = 2,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req_valid,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_grant_idx,
    output logic            o_any_grant
);
    logic [NREQ-1:0] w_rot;
    // bit k of w_rot is requester (last+1+k) mod NREQ
    assign w_rot = NREQ'({i_req_valid, i_req_valid} >> (int'(i_last) + 1));
    always_comb begin
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_grant_idx = IW'((int'(i_last) + 1 + k) % NREQ);
                o_any_grant = 1'b1;
            end
        end
    end
    assign o_grant = o_any_grant ? NREQ'(1) << o_grant_idx : '0;
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB bus between NREQ requesters with round-robin grant
// and back-to-back SETUP/ACCESS sequencing.
module apb_master_arbiter import apb_pkg::*; #(
    parameter int NREQ   = 2,
    parameter int AWIDTH = APB_AWIDTH,
    parameter int DWIDTH = APB_DWIDTH
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*AWIDTH-1:0] req_addr,
    input  logic [NREQ*DWIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DWIDTH-1:0]      rsp_rdata,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [AWIDTH-1:0]      paddr,
    output logic [DWIDTH-1:0]      pwdata,
    input  logic [DWIDTH-1:0]      prdata,
    input  logic                   pready
);
    localparam int IW = idx_w(NREQ);
    apb_state_t r_state, w_next;
    logic [IW-1:0] r_last, r_owner, w_idx;
    logic [NREQ-1:0] w_grant;
    logic w_any, w_done, w_accept;
    logic [AWIDTH-1:0] w_addr [NREQ];
    logic [DWIDTH-1:0] w_wdata [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_addr[i]  = req_addr[i*AWIDTH +: AWIDTH];
        assign w_wdata[i] = req_wdata[i*DWIDTH +: DWIDTH];
    end
    apb_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .i_req_valid (req_valid),
        .i_last      (r_last),
        .o_grant     (w_grant),
        .o_grant_idx (w_idx),
        .o_any_grant (w_any)
    );
    assign w_done    = r_state == ACCESS && pready;
    // gated by reset so no command is accepted while the block is held in reset
    assign w_accept  = !preset && w_any && (r_state == IDLE || w_done);
    assign req_ready = w_accept ? w_grant : '0;
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = w_accept ? SETUP : r_state == SETUP ? ACCESS : w_done ? IDLE : r_state;
    end
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_last    <= IW'(NREQ - 1);
            r_owner   <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            psel      <= w_next != IDLE;
            penable   <= w_next == ACCESS;
            rsp_valid <= w_done ? NREQ'(1) << r_owner : '0;
            if (w_done && !pwrite) rsp_rdata <= prdata;
            if (w_accept) begin
                r_last  <= w_idx;
                r_owner <= w_idx;
                pwrite  <= req_write[w_idx];
                paddr   <= w_addr[w_idx];
                pwdata  <= w_wdata[w_idx];
            end
        end
    end
endmodule
